// File: rtl/bw_mon_pkg.sv
// Shared types, default sizing and saturating arithmetic for the bandwidth monitor.
package bw_mon_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } bw_mon_state_e;

  localparam int unsigned DEF_NUM_CH       = 2;
  localparam int unsigned DEF_BEAT_BYTES_W = 4;
  localparam int unsigned DEF_WIN_W        = 16;
  localparam int unsigned DEF_CNT_W        = 32;

  // a + b clamped to 2^width-1; width must be below 64.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned width);
    logic [63:0] max_val;
    logic [63:0] total;
    max_val = (64'd1 << width) - 64'd1;
    total   = a + b;
    return (total > max_val) ? max_val : total;
  endfunction

endpackage

// File: rtl/bw_sat_accum.sv
// Saturating accumulator. sum/sat present the running total and clamp flag
// including this cycle's increment, so a window-end snapshot can take them directly.
module bw_sat_accum
  import bw_mon_pkg::*;
#(
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned INC_W = DEF_BEAT_BYTES_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [INC_W-1:0] inc,
  output logic [CNT_W-1:0] sum,
  output logic             sat
);

  logic [CNT_W-1:0] acc_q;
  logic             sat_q;
  logic [INC_W-1:0] inc_eff;
  logic [CNT_W:0]   wide;

  // Running total and clamp detection for the current cycle.
  always_comb begin
    inc_eff = en ? inc : '0;
    wide    = {1'b0, acc_q} + (CNT_W + 1)'(inc_eff);
    sum     = CNT_W'(sat_add(64'(acc_q), 64'(inc_eff), CNT_W));
    sat     = sat_q | wide[CNT_W];
  end

  // Accumulator register; clr discards the total at the next edge.
  always_ff @(posedge clock) begin
    if (!reset || clr) begin
      acc_q <= '0;
      sat_q <= 1'b0;
    end else if (en) begin
      acc_q <= sum;
      sat_q <= sat;
    end
  end

endmodule

// File: rtl/windowed_bw_monitor.sv
// Windowed raw/compressed byte and stall monitor with a valid/ack snapshot port.
module windowed_bw_monitor
  import bw_mon_pkg::*;
#(
  parameter int unsigned NUM_CH       = DEF_NUM_CH,
  parameter int unsigned BEAT_BYTES_W = DEF_BEAT_BYTES_W,
  parameter int unsigned WIN_W        = DEF_WIN_W,
  parameter int unsigned CNT_W        = DEF_CNT_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           clear,
  input  logic [WIN_W-1:0]               window_len,
  input  logic                           raw_valid,
  input  logic                           raw_ready,
  input  logic [BEAT_BYTES_W-1:0]        raw_bytes,
  input  logic [NUM_CH-1:0]              out_valid,
  input  logic [NUM_CH-1:0]              out_ready,
  input  logic [NUM_CH*BEAT_BYTES_W-1:0] out_bytes,
  output logic                           snap_valid,
  input  logic                           snap_ack,
  output logic [CNT_W-1:0]               snap_raw_bytes,
  output logic [CNT_W-1:0]               snap_out_bytes,
  output logic [CNT_W-1:0]               snap_stall_cycles,
  output logic                           snap_sat,
  output logic                           snap_overrun
);

  localparam int unsigned SUM_W = BEAT_BYTES_W + $clog2(NUM_CH) + 1;

  bw_mon_state_e state_q, state_d;
  logic [WIN_W-1:0]        len_q, cnt_q;
  logic                    measuring, win_end, acc_clr;
  logic [BEAT_BYTES_W-1:0] raw_inc;
  logic [SUM_W-1:0]        out_inc;
  logic                    stall_inc;
  logic [CNT_W-1:0]        raw_sum, out_sum, stall_sum;
  logic                    raw_sat, out_sat, stall_sat;

  // Next-state logic: enable alone moves between IDLE and RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable)  state_d = RUN;
      RUN:     if (!enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Per-cycle event decode and window control.
  always_comb begin
    measuring = (state_q == RUN) && enable;
    win_end   = measuring && (cnt_q == len_q - WIN_W'(1));
    acc_clr   = clear || win_end || !measuring;
    raw_inc   = (raw_valid && raw_ready) ? raw_bytes : '0;
    stall_inc = |(out_valid & ~out_ready);
    out_inc   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (out_valid[i] && out_ready[i])
        out_inc = out_inc + SUM_W'(out_bytes[i*BEAT_BYTES_W +: BEAT_BYTES_W]);
    end
  end

  // Window length latch and cycle counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      len_q <= '0;
      cnt_q <= '0;
    end else begin
      if (state_q == IDLE && enable)
        len_q <= (window_len == '0) ? WIN_W'(1) : window_len;
      if (acc_clr) cnt_q <= '0;
      else         cnt_q <= cnt_q + WIN_W'(1);
    end
  end

  bw_sat_accum #(.CNT_W(CNT_W), .INC_W(BEAT_BYTES_W)) u_raw_acc (
    .clock(clock), .reset(reset), .clr(acc_clr), .en(measuring),
    .inc(raw_inc), .sum(raw_sum), .sat(raw_sat)
  );

  bw_sat_accum #(.CNT_W(CNT_W), .INC_W(SUM_W)) u_out_acc (
    .clock(clock), .reset(reset), .clr(acc_clr), .en(measuring),
    .inc(out_inc), .sum(out_sum), .sat(out_sat)
  );

  bw_sat_accum #(.CNT_W(CNT_W), .INC_W(1)) u_stall_acc (
    .clock(clock), .reset(reset), .clr(acc_clr), .en(measuring),
    .inc(stall_inc), .sum(stall_sum), .sat(stall_sat)
  );

  // Snapshot register: clear beats window-end load, which beats ack.
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      snap_valid        <= 1'b0;
      snap_raw_bytes    <= '0;
      snap_out_bytes    <= '0;
      snap_stall_cycles <= '0;
      snap_sat          <= 1'b0;
      snap_overrun      <= 1'b0;
    end else if (win_end) begin
      snap_valid        <= 1'b1;
      snap_raw_bytes    <= raw_sum;
      snap_out_bytes    <= out_sum;
      snap_stall_cycles <= stall_sum;
      snap_sat          <= raw_sat | out_sat | stall_sat;
      if (snap_valid && !snap_ack) snap_overrun <= 1'b1;
    end else if (snap_valid && snap_ack) begin
      snap_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_windowed_bw_monitor.sv
// Directed bench for windowed_bw_monitor: a 32-bit and an 8-bit counter instance
// share one stimulus; a window-level model predicts both every cycle.
module tb_windowed_bw_monitor;

  logic        clock = 1'b0;
  logic        reset, enable, clear, snap_ack;
  logic [15:0] window_len;
  logic        raw_valid, raw_ready;
  logic [3:0]  raw_bytes;
  logic [1:0]  out_valid, out_ready;
  logic [7:0]  out_bytes;

  logic        a_valid, a_sat, a_ov;
  logic [31:0] a_raw, a_out, a_stall;
  logic        b_valid, b_sat, b_ov;
  logic [7:0]  b_raw, b_out, b_stall;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  windowed_bw_monitor dut_a (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .window_len(window_len),
    .raw_valid(raw_valid), .raw_ready(raw_ready), .raw_bytes(raw_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes),
    .snap_valid(a_valid), .snap_ack(snap_ack), .snap_raw_bytes(a_raw),
    .snap_out_bytes(a_out), .snap_stall_cycles(a_stall), .snap_sat(a_sat),
    .snap_overrun(a_ov)
  );

  windowed_bw_monitor #(.CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .enable(enable), .clear(clear), .window_len(window_len),
    .raw_valid(raw_valid), .raw_ready(raw_ready), .raw_bytes(raw_bytes),
    .out_valid(out_valid), .out_ready(out_ready), .out_bytes(out_bytes),
    .snap_valid(b_valid), .snap_ack(snap_ack), .snap_raw_bytes(b_raw),
    .snap_out_bytes(b_out), .snap_stall_cycles(b_stall), .snap_sat(b_sat),
    .snap_overrun(b_ov)
  );

  // ---------------- window-level model (index 0: CNT_W=32, 1: CNT_W=8)
  localparam longint MAX_A = 64'h0000_0000_FFFF_FFFF;
  localparam longint MAX_B = 255;

  longint m_raw [2] = '{0, 0};
  longint m_out [2] = '{0, 0};
  longint m_stl [2] = '{0, 0};
  bit     m_sat [2] = '{0, 0};
  longint s_raw [2] = '{0, 0};
  longint s_out [2] = '{0, 0};
  longint s_stl [2] = '{0, 0};
  bit     s_sat [2] = '{0, 0};
  bit     s_val [2] = '{0, 0};
  bit     s_ov  [2] = '{0, 0};
  bit     m_run = 0;
  longint m_cnt = 0;
  longint m_len = 0;

  function automatic longint clampv(longint v, longint mx);
    return (v > mx) ? mx : v;
  endfunction

  always @(posedge clock) begin : model
    longint ri, oi, si, nr, no, ns, mx;
    bit meas, wend, ws;
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        m_raw[k] = 0; m_out[k] = 0; m_stl[k] = 0; m_sat[k] = 0;
        s_raw[k] = 0; s_out[k] = 0; s_stl[k] = 0; s_sat[k] = 0;
        s_val[k] = 0; s_ov[k] = 0;
      end
      m_run = 0; m_cnt = 0; m_len = 0;
    end else begin
      ri = (raw_valid && raw_ready) ? longint'(raw_bytes) : 0;
      oi = 0;
      for (int c = 0; c < 2; c++)
        if (out_valid[c] && out_ready[c]) oi += (longint'(out_bytes) >> (4 * c)) & 15;
      si = ((out_valid & ~out_ready) != 2'b00) ? 1 : 0;
      meas = m_run && enable;
      wend = meas && (m_cnt == m_len - 1);
      for (int k = 0; k < 2; k++) begin
        mx = (k == 0) ? MAX_A : MAX_B;
        nr = m_raw[k] + ri; no = m_out[k] + oi; ns = m_stl[k] + si;
        ws = m_sat[k] || nr > mx || no > mx || ns > mx;
        nr = clampv(nr, mx); no = clampv(no, mx); ns = clampv(ns, mx);
        if (clear) begin
          s_raw[k] = 0; s_out[k] = 0; s_stl[k] = 0; s_sat[k] = 0; s_val[k] = 0; s_ov[k] = 0;
          m_raw[k] = 0; m_out[k] = 0; m_stl[k] = 0; m_sat[k] = 0;
        end else if (wend) begin
          if (s_val[k] && !snap_ack) s_ov[k] = 1;
          s_raw[k] = nr; s_out[k] = no; s_stl[k] = ns; s_sat[k] = ws; s_val[k] = 1;
          m_raw[k] = 0; m_out[k] = 0; m_stl[k] = 0; m_sat[k] = 0;
        end else begin
          if (s_val[k] && snap_ack) s_val[k] = 0;
          if (meas) begin
            m_raw[k] = nr; m_out[k] = no; m_stl[k] = ns; m_sat[k] = ws;
          end else begin
            m_raw[k] = 0; m_out[k] = 0; m_stl[k] = 0; m_sat[k] = 0;
          end
        end
      end
      if (clear || !meas || wend) m_cnt = 0;
      else                        m_cnt = m_cnt + 1;
      if (!m_run && enable) begin
        m_run = 1;
        m_len = (window_len == 16'd0) ? 1 : longint'(window_len);
      end else if (m_run && !enable) begin
        m_run = 0;
      end
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison of both instances against the model.
  always @(posedge clock) begin
    #1;
    chk("a_valid", longint'(a_valid), longint'(s_val[0]));
    chk("a_raw",   longint'(a_raw),   s_raw[0]);
    chk("a_out",   longint'(a_out),   s_out[0]);
    chk("a_stall", longint'(a_stall), s_stl[0]);
    chk("a_sat",   longint'(a_sat),   longint'(s_sat[0]));
    chk("a_ovr",   longint'(a_ov),    longint'(s_ov[0]));
    chk("b_valid", longint'(b_valid), longint'(s_val[1]));
    chk("b_raw",   longint'(b_raw),   s_raw[1]);
    chk("b_out",   longint'(b_out),   s_out[1]);
    chk("b_stall", longint'(b_stall), s_stl[1]);
    chk("b_sat",   longint'(b_sat),   longint'(s_sat[1]));
    chk("b_ovr",   longint'(b_ov),    longint'(s_ov[1]));
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- directed stimulus with hand-computed expectations
  initial begin
    reset = 1'b0; enable = 1'b0; clear = 1'b0; snap_ack = 1'b0; window_len = 16'd8;
    raw_valid = 1'b0; raw_ready = 1'b1; raw_bytes = 4'd0;
    out_valid = 2'b00; out_ready = 2'b11; out_bytes = 8'h00;
    cyc(3);
    chk("rst_valid", longint'(a_valid), 0);
    chk("rst_raw",   longint'(a_raw),   0);
    reset = 1'b1;
    cyc(1);

    // Test 1: 6 raw bytes and 3 ch0 bytes per cycle, window 8
    raw_valid = 1'b1; raw_bytes = 4'd6; out_valid = 2'b01; out_bytes = 8'h03; enable = 1'b1;
    cyc(8);
    chk("t1_not_yet", longint'(a_valid), 0);
    cyc(1);
    chk("t1_valid", longint'(a_valid), 1);
    chk("t1_raw",   longint'(a_raw),   48);
    chk("t1_out",   longint'(a_out),   24);
    chk("t1_stall", longint'(a_stall), 0);
    snap_ack = 1'b1; enable = 1'b0;
    cyc(1);
    snap_ack = 1'b0;
    chk("t1_acked", longint'(a_valid), 0);

    // Test 2: overlapping stalls on both channels, 5 stall cycles
    raw_valid = 1'b0; out_valid = 2'b11; out_bytes = 8'h52; enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      case (i)
        1, 5:    out_ready = 2'b10;
        2, 3, 4: out_ready = 2'b00;
        default: out_ready = 2'b11;
      endcase
      cyc(1);
    end
    chk("t2_valid", longint'(a_valid), 1);
    chk("t2_stall", longint'(a_stall), 5);
    chk("t2_out",   longint'(a_out),   31);
    chk("t2_ovr",   longint'(a_ov),    0);

    // Test 3: overrun, then ack coinciding with a load
    out_ready = 2'b11; out_bytes = 8'h11;
    cyc(8);
    chk("t3_ovr",   longint'(a_ov),  1);
    chk("t3_out",   longint'(a_out), 16);
    cyc(7);
    snap_ack = 1'b1;
    cyc(1);
    snap_ack = 1'b0;
    chk("t3_load_wins", longint'(a_valid), 1);
    chk("t3_ovr_kept",  longint'(a_ov),    1);
    snap_ack = 1'b1;
    cyc(1);
    snap_ack = 1'b0;
    chk("t3_acked", longint'(a_valid), 0);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t3_clr_ovr", longint'(a_ov), 0);
    enable = 1'b0;
    cyc(2);

    // Test 4: enable dropped mid-window, snapshot preserved
    out_valid = 2'b00; raw_valid = 1'b1; raw_bytes = 4'd4; window_len = 16'd8; enable = 1'b1;
    cyc(9);
    chk("t4_first", longint'(a_raw), 32);
    cyc(3);
    enable = 1'b0;
    cyc(4);
    chk("t4_kept_valid", longint'(a_valid), 1);
    chk("t4_kept_raw",   longint'(a_raw),   32);
    raw_bytes = 4'd1; enable = 1'b1;
    cyc(9);
    chk("t4_post_raw", longint'(a_raw), 8);
    chk("t4_post_ovr", longint'(a_ov),  1);
    snap_ack = 1'b1; enable = 1'b0;
    cyc(1);
    snap_ack = 1'b0; clear = 1'b1;
    cyc(1);
    clear = 1'b0;

    // Test 5: saturation on the 8-bit instance
    window_len = 16'd32; raw_bytes = 4'd15; enable = 1'b1;
    cyc(33);
    chk("t5_a_raw", longint'(a_raw), 480);
    chk("t5_a_sat", longint'(a_sat), 0);
    chk("t5_b_raw", longint'(b_raw), 255);
    chk("t5_b_sat", longint'(b_sat), 1);
    raw_valid = 1'b0;
    cyc(32);
    chk("t5_quiet_sat", longint'(b_sat), 0);
    chk("t5_quiet_raw", longint'(b_raw), 0);

    // Test 6: clear on a window-end cycle, then reset with a pending snapshot
    raw_valid = 1'b1; raw_bytes = 4'd2;
    cyc(31);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("t6_clr_valid", longint'(a_valid), 0);
    chk("t6_clr_raw",   longint'(a_raw),   0);
    cyc(32);
    chk("t6_valid", longint'(a_valid), 1);
    chk("t6_raw",   longint'(a_raw),   64);
    cyc(5);
    reset = 1'b0;
    cyc(1);
    chk("t6_rst_valid", longint'(a_valid), 0);
    chk("t6_rst_raw",   longint'(a_raw),   0);
    window_len = 16'd4;
    reset = 1'b1;
    cyc(4);
    chk("t6_idle_first", longint'(a_valid), 0);
    cyc(1);
    chk("t6_restart_valid", longint'(a_valid), 1);
    chk("t6_restart_raw",   longint'(a_raw),   8);

    enable = 1'b0;
    cyc(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
